// File: rtl/iter_div_axis.sv
// Radix-2 restoring divider on two AXI-stream operand channels.
// It produces {quotient, remainder} 34 cycles after the last operand transfer.
module iter_div_axis #(
    parameter bit SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_axis_divisor_tvalid,
    output logic        s_axis_divisor_tready,
    input  logic [31:0] s_axis_divisor_tdata,
    input  logic        s_axis_dividend_tvalid,
    output logic        s_axis_dividend_tready,
    input  logic [31:0] s_axis_dividend_tdata,
    output logic        m_axis_dout_tvalid,
    output logic [63:0] m_axis_dout_tdata
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  count_reg;
    logic [32:0] rem_reg;
    logic [31:0] quo_reg;
    logic [31:0] div_reg;
    logic        dout_valid_reg;
    logic [63:0] dout_data_reg;

    // Channel 0 is the dividend, channel 1 the divisor; both follow the same capture rule.
    logic [1:0]  ch_valid;
    logic [31:0] ch_data  [2];
    logic [1:0]  ch_ready;
    logic [1:0]  ch_full;
    logic [31:0] ch_slot  [2];

    assign ch_valid   = {s_axis_divisor_tvalid, s_axis_dividend_tvalid};
    assign ch_data[0] = s_axis_dividend_tdata;
    assign ch_data[1] = s_axis_divisor_tdata;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic        ready_reg;
            logic        full_reg;
            logic [31:0] slot_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    ready_reg <= 1'b0;
                    full_reg  <= 1'b0;
                    slot_reg  <= '0;
                end else begin
                    ready_reg <= ch_valid[gi] & ~ready_reg & ~full_reg & (state_reg == IDLE);
                    if (state_reg == DONE) begin
                        full_reg <= 1'b0;
                    end else if (ch_valid[gi] & ready_reg) begin
                        full_reg <= 1'b1;
                        slot_reg <= ch_data[gi];
                    end
                end
            end

            assign ch_ready[gi] = ready_reg;
            assign ch_full[gi]  = full_reg;
            assign ch_slot[gi]  = slot_reg;
        end
    endgenerate

    function automatic logic [31:0] magnitude(input logic [31:0] x);
        return (SIGNED && x[31]) ? (~x + 32'd1) : x;
    endfunction

    logic        dvd_neg, dvs_neg, div_zero;
    logic [33:0] shifted;
    logic [33:0] trial;
    logic [31:0] quo_fix, rem_fix;

    assign dvd_neg  = SIGNED && ch_slot[0][31];
    assign dvs_neg  = SIGNED && ch_slot[1][31];
    assign div_zero = (ch_slot[1] == 32'd0);

    // The remainder never exceeds 32 significant bits, so bit 33 of trial is the borrow.
    assign shifted = {rem_reg, quo_reg[31]};
    assign trial   = shifted - {2'b00, div_reg};

    // A zero divisor leaves the all-ones quotient and the raw dividend untouched.
    assign quo_fix = div_zero ? 32'hFFFF_FFFF :
                     (dvd_neg ^ dvs_neg) ? (~quo_reg + 32'd1) : quo_reg;
    assign rem_fix = div_zero ? ch_slot[0] :
                     dvd_neg ? (~rem_reg[31:0] + 32'd1) : rem_reg[31:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (&ch_full) state_next = CALC;
            CALC:    if (count_reg == 5'd31) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg      <= '0;
            rem_reg        <= '0;
            quo_reg        <= '0;
            div_reg        <= '0;
            dout_valid_reg <= 1'b0;
            dout_data_reg  <= '0;
        end else begin
            dout_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (state_next == CALC) begin
                        count_reg <= '0;
                        rem_reg   <= '0;
                        quo_reg   <= magnitude(ch_slot[0]);
                        div_reg   <= magnitude(ch_slot[1]);
                    end
                end
                CALC: begin
                    count_reg <= 5'(count_reg + 5'd1);
                    if (!trial[33]) begin
                        rem_reg <= trial[32:0];
                        quo_reg <= {quo_reg[30:0], 1'b1};
                    end else begin
                        rem_reg <= shifted[32:0];
                        quo_reg <= {quo_reg[30:0], 1'b0};
                    end
                end
                FIX: begin
                    dout_valid_reg <= 1'b1;
                    dout_data_reg  <= {quo_fix, rem_fix};
                end
                default: ;
            endcase
        end
    end

    assign s_axis_dividend_tready = ch_ready[0];
    assign s_axis_divisor_tready  = ch_ready[1];
    assign m_axis_dout_tvalid     = dout_valid_reg;
    assign m_axis_dout_tdata      = dout_data_reg;

endmodule

// File: tb/tb_iter_div_axis.sv
// Bench for iter_div_axis: an unsigned and a signed instance share the operand
// channels and are compared against an arithmetic reference model.
module tb_iter_div_axis;

    logic        clk = 1'b0;
    logic        reset;
    logic        dvs_valid, dvd_valid;
    logic [31:0] dvs_data, dvd_data;

    logic        dvs_ready_u, dvd_ready_u, dout_valid_u;
    logic [63:0] dout_data_u;
    logic        dvs_ready_s, dvd_ready_s, dout_valid_s;
    logic [63:0] dout_data_s;

    int checks   = 0;
    int failures = 0;
    int op_num   = 0;

    always #5 clk = ~clk;

    iter_div_axis #(.SIGNED(1'b0)) dut_u (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_divisor_tvalid  (dvs_valid),
        .s_axis_divisor_tready  (dvs_ready_u),
        .s_axis_divisor_tdata   (dvs_data),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (dvd_ready_u),
        .s_axis_dividend_tdata  (dvd_data),
        .m_axis_dout_tvalid     (dout_valid_u),
        .m_axis_dout_tdata      (dout_data_u)
    );

    iter_div_axis #(.SIGNED(1'b1)) dut_s (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_divisor_tvalid  (dvs_valid),
        .s_axis_divisor_tready  (dvs_ready_s),
        .s_axis_divisor_tdata   (dvs_data),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (dvd_ready_s),
        .s_axis_dividend_tdata  (dvd_data),
        .m_axis_dout_tvalid     (dout_valid_s),
        .m_axis_dout_tdata      (dout_data_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division with the documented zero-divisor and overflow results.
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (!sgn) return {a / b, a % b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
        sa = int'(a);
        sb = int'(b);
        q  = sa / sb;
        r  = sa % sb;
        return {32'(q), 32'(r)};
    endfunction

    // Execute-stage style driver: registered tvalid per channel, dropped after the transfer edge.
    task automatic start_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input int gap_a, input int gap_b);
        int t, ta, tb;
        bit da, db, xa, xb;
        t = 0; ta = -1; tb = -1; da = 0; db = 0;
        while (!(da && db) && t < 300) begin
            if (!da && t == gap_a) begin dvd_valid = 1'b1; dvd_data = a; end
            if (!db && t == gap_b) begin dvs_valid = 1'b1; dvs_data = b; end
            @(negedge clk);
            xa = dvd_valid && dvd_ready_u;
            xb = dvs_valid && dvs_ready_u;
            if (dvd_ready_u !== dvd_ready_s || dvs_ready_u !== dvs_ready_s)
                chk({tag, "_ready_match"}, {62'd0, dvd_ready_s, dvs_ready_s}, {62'd0, dvd_ready_u, dvs_ready_u});
            @(posedge clk);
            #1;
            if (xa) begin dvd_valid = 1'b0; dvd_data = $urandom; da = 1; ta = t; end
            if (xb) begin dvs_valid = 1'b0; dvs_data = $urandom; db = 1; tb = t; end
            t++;
        end
        chk({tag, "_handshake"}, {62'd0, da, db}, 64'd3);
        chk({tag, "_xfer_delay"}, 64'(ta - gap_a) << 32 | 64'(tb - gap_b), {32'd1, 32'd1});
    endtask

    task automatic finish_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        int latency;
        bit seen;
        logic [63:0] exp_u, exp_s;
        exp_u = model(1'b0, a, b);
        exp_s = model(1'b1, a, b);
        latency = 0; seen = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (dout_valid_u || dout_valid_s) begin latency = k; seen = 1; end
        end
        chk({tag, "_latency"}, 64'(latency), 64'd34);
        chk({tag, "_valid_both"}, {62'd0, dout_valid_u, dout_valid_s}, 64'd3);
        chk({tag, "_udata"}, dout_data_u, exp_u);
        chk({tag, "_sdata"}, dout_data_s, exp_s);
        @(posedge clk);
        #1;
        chk({tag, "_pulse_width"}, {62'd0, dout_valid_u, dout_valid_s}, 64'd0);
        chk({tag, "_hold"}, {dout_data_u ^ exp_u} | {dout_data_s ^ exp_s}, 64'd0);
        $display("op %0d %s a=%h b=%h u=%h s=%h lat=%0d", op_num, tag, a, b,
                 dout_data_u, dout_data_s, latency);
        op_num++;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int gap_a, input int gap_b);
        start_op(tag, a, b, gap_a, gap_b);
        finish_op(tag, a, b);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        int seen_abort;

        reset = 1'b1;
        dvs_valid = 1'b0; dvd_valid = 1'b0;
        dvs_data = '0; dvd_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready_u", {62'd0, dvd_ready_u, dvs_ready_u}, 64'd0);
        chk("reset_ready_s", {62'd0, dvd_ready_s, dvs_ready_s}, 64'd0);
        chk("reset_valid", {62'd0, dout_valid_u, dout_valid_s}, 64'd0);
        chk("reset_data_u", dout_data_u, 64'd0);
        chk("reset_data_s", dout_data_s, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op("u7_2", 32'd7, 32'd2, 0, 0);
        chk("u7_2_const", dout_data_u, 64'h00000003_00000001);
        run_op("sneg7_2", 32'hFFFF_FFF9, 32'd2, 0, 0);
        chk("sneg7_2_const", dout_data_s, 64'hFFFFFFFD_FFFFFFFF);
        run_op("s7_neg2", 32'd7, 32'hFFFF_FFFE, 0, 0);
        chk("s7_neg2_const", dout_data_s, 64'hFFFFFFFD_00000001);
        run_op("stagger", 32'd100, 32'd7, 0, 10);
        chk("stagger_const", dout_data_u, 64'h0000000E_00000002);
        run_op("divisor_first", 32'd1000, 32'd33, 6, 0);
        run_op("div0", 32'h1234_5678, 32'd0, 0, 0);
        chk("div0_const", dout_data_u, 64'hFFFFFFFF_12345678);
        run_op("sdiv0_neg", 32'hFFFF_FF00, 32'd0, 1, 0);
        run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        chk("ovf_const", dout_data_s, 64'h80000000_00000000);
        run_op("max_div1", 32'hFFFF_FFFF, 32'd1, 0, 0);
        chk("max_div1_const", dout_data_u, 64'hFFFFFFFF_00000000);

        // Abort a job mid-calculation; nothing may be emitted for it.
        start_op("abort", 32'd50, 32'd5, 0, 0);
        repeat (11) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen_abort = 0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk);
            #1;
            if (dout_valid_u || dout_valid_s) seen_abort++;
        end
        chk("abort_no_valid", 64'(seen_abort), 64'd0);
        chk("abort_data_u", dout_data_u, 64'd0);
        chk("abort_data_s", dout_data_s, 64'd0);
        run_op("after_abort", 32'd9, 32'd3, 0, 0);
        chk("after_abort_const", dout_data_u, 64'h00000003_00000000);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       rb = 32'd1;
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = 32'h8000_0000;
                4, 5:    rb = 32'($urandom_range(1, 255));
                6:       rb = 32'(-int'($urandom_range(1, 255)));
                default: rb = $urandom;
            endcase
            ra = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
            run_op("rand", ra, rb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iter_div_axis.md
Name: iter_div_axis

Overview:
- In-house radix-2 iterative divider. It is the responder end of the AXI-stream divider interface driven by the execute-stage div/divu handshake FSM.
- Drop-in replacement for the vendor signed/unsigned divider IPs. One instance has SIGNED=1 and one has SIGNED=0.
- It accepts the divisor and dividend on independent valid/ready channels, computes for a fixed number of cycles, then pulses a 64-bit {quotient, remainder} result.

Parameters:
- SIGNED, 1: 1 selects two's-complement division truncated toward zero; 0 selects unsigned division.

Ports:
- clk  input  1  sole clock; all state is updated on the rising edge.
- reset  input  1  synchronous, active-high reset.
- s_axis_divisor_tvalid  input  1  divisor offered.
- s_axis_divisor_tready  output  1  divisor accepted in this cycle (registered).
- s_axis_divisor_tdata  input  32  divisor.
- s_axis_dividend_tvalid  input  1  dividend offered.
- s_axis_dividend_tready  output  1  dividend accepted in this cycle (registered).
- s_axis_dividend_tdata  input  32  dividend.
- m_axis_dout_tvalid  output  1  one-cycle result strobe; there is no backpressure.
- m_axis_dout_tdata  output  64  [63:32] quotient, [31:0] remainder.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - both tready outputs = 0, m_axis_dout_tvalid = 0, m_axis_dout_tdata = 0;
  - operand slots empty; state = IDLE; iteration counter = 0.
- Reset mid-operation discards everything; no result is emitted for the aborted operation.
- Per-channel capture (identical rule for both channels, channels independent):
  - tready_next = tvalid & ~tready & slot_empty & (state==IDLE).
  - tready is therefore high for at most one cycle, and only in the cycle after tvalid was seen.
  - Transfer occurs on a rising edge where tvalid & tready are both 1. At that edge tdata is latched into the slot and the slot is marked full.
  - If tvalid is low while tready is high, no transfer occurs; tready returns to 0 next cycle and the rule re-arms.
  - A full slot keeps tready at 0.
- The two channels may transfer in the same cycle or in any order, with any gap between them.
- States:
  - IDLE: collect operands. When both slots are full → CALC, with count=0.
  - CALC:
    - On entry, load |dividend| into the quotient/shift register and |divisor| into the divisor register. Magnitudes are taken only when SIGNED=1; otherwise raw values are used.
    - Clear the partial remainder (33 bits).
    - Each cycle performs one restoring step: shift {rem,quo} left by 1; trial = rem − divisor; if non-negative, rem = trial and quo[0] = 1.
    - After 32 steps (count==31) → FIX.
  - FIX:
    - If SIGNED and the operand signs differ, negate the quotient.
    - If SIGNED and the dividend is negative, negate the remainder.
    - → DONE.
  - DONE:
    - m_axis_dout_tvalid = 1 for exactly this one cycle; tdata is updated on entry.
    - Clear both slots → IDLE.
- Latency: tvalid rises exactly 34 cycles after the rising edge that accepted the last operand. Throughput is one division per ≥36 cycles, including the handshake.
- m_axis_dout_tdata holds its value after the strobe until the next DONE.
- Both tready outputs stay 0 from slot-full through DONE. Operands offered during computation wait.
- Divide by zero (both modes), no exception: quotient = 32'hFFFF_FFFF, remainder = dividend unchanged. The FIX negation is suppressed in this case.
- Signed overflow (0x8000_0000 / 0xFFFF_FFFF): quotient = 0x8000_0000, remainder = 0. This is a natural wrap and must fall out of 33-bit magnitude arithmetic.
- Remainder identity: dividend = quotient*divisor + remainder (mod 2^32). In SIGNED mode, |remainder| < |divisor| and the remainder is either zero or carries the dividend's sign.
- tdata inputs are sampled only at the transfer edge; later changes are ignored.

Test Plan:
- Unsigned 7/2: both tvalid asserted together → tready pulses at cycle+1 on both channels; 34 cycles later dout_tvalid pulses for 1 cycle with tdata=64'h00000003_00000001.
- Signed −7/2 (0xFFFFFFF9 / 0x00000002) → tdata=64'hFFFFFFFD_FFFFFFFF. Signed 7/−2 → 64'hFFFFFFFD_00000001.
- Staggered arrival: dividend 100 accepted, divisor 7 offered 10 cycles later → no activity until the divisor transfer; result 64'h0000000E_00000002 exactly 34 cycles after the divisor transfer edge.
- Corner cases:
  - Divide by zero, unsigned 0x12345678/0 → 64'hFFFFFFFF_12345678.
  - Signed 0x80000000/0xFFFFFFFF → 64'h80000000_00000000.
  - Unsigned 0xFFFFFFFF/1 → 64'hFFFFFFFF_00000000.
- Reset asserted 10 cycles into CALC, then released → no dout_tvalid for the aborted job; outputs read 0. A fresh 9/3 then yields 64'h00000003_00000000 with nominal latency.
- Integration with the execute-stage handshake FSM (registered tvalid that drops once tready is seen): 200 random back-to-back div/divu ops compared against a reference model → zero mismatches, no deadlock, and no double-capture of an operand.
